// File: rtl/sram_like_responder_pkg.sv
// rtl/sram_like_responder_pkg.sv - shared defaults, widths and access-size encoding
package sram_like_responder_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 10;
  localparam int DEFAULT_LATENCY    = 2;
  localparam int DEFAULT_MAX_OUT    = 4;
  localparam int DATA_W             = 32;
  localparam int AGE_W              = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - in-order pending-response queue with per-entry saturating age
module sram_resp_fifo
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_MAX_OUT,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_ready,
  output logic              full,
  output logic [CW-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A freshly pushed entry is already one cycle old when it becomes visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr == PW'(i))  age_q[i] <= AGE_W'(1);
        else if (age_q[i] < AGE_MAX)   age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_q[wr_ptr] <= push_data;
  end

  assign head_data  = data_q[rd_ptr];
  assign head_ready = (count != '0) && (age_q[rd_ptr] >= AGE_MAX - AGE_W'(1));
  assign full       = (count == CW'(DEPTH));

endmodule

// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - SRAM-like target with fixed minimum latency and in-order responses
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int MAX_OUT    = DEFAULT_MAX_OUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        hold,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  bypass;
  logic                  head_ready;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         outstanding;
  logic [31:0]           head_data;
  logic [31:0]           resp_word;
  size_e                 access_size;
  logic                  unused_bits;

  assign idx         = addr[DEPTH_LOG2+1:2];
  assign access_size = size_e'(size);
  assign unused_bits = ^{access_size, addr[31:DEPTH_LOG2+2], addr[1:0]};

  // The response sitting in the output register is still outstanding.
  assign outstanding = fifo_count + CW'(data_ok);
  assign addr_ok     = !hold && !fifo_full && (outstanding < CW'(MAX_OUT));
  assign accept      = req && addr_ok;
  assign resp_word   = wr ? 32'h0 : mem[idx];
  // With single-cycle latency an idle queue would add a cycle, so answer directly.
  assign bypass      = (LATENCY == 1) && accept && (fifo_count == '0);

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  sram_resp_fifo #(
    .DEPTH   (MAX_OUT),
    .LATENCY (LATENCY),
    .CW      (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push       (accept && !bypass),
    .push_data  (resp_word),
    .pop        (head_ready),
    .head_data  (head_data),
    .head_ready (head_ready),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ok <= 1'b0;
      rdata   <= 32'h0;
    end else if (head_ready) begin
      data_ok <= 1'b1;
      rdata   <= head_data;
    end else if (bypass) begin
      data_ok <= 1'b1;
      rdata   <= resp_word;
    end else begin
      data_ok <= 1'b0;
      rdata   <= 32'h0;
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb/tb_sram_like_responder.sv - directed self-checking bench for sram_like_responder
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, bp_req, wr, hold;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, bp_addr_ok, bp_data_ok;
  logic [31:0] rdata, bp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          acc_cyc[$];
  int          rsp_cyc[$];
  logic [31:0] rsp_dat[$];
  logic [31:0] bp_rsp_dat[$];
  int          bp_out = 0;
  int          bp_out_max = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_responder u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .hold(hold),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_responder #(.LATENCY(6), .MAX_OUT(4)) u_bp (
    .clk(clk), .reset(reset), .req(bp_req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .hold(hold),
    .addr_ok(bp_addr_ok), .data_ok(bp_data_ok), .rdata(bp_rdata)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (req && addr_ok) acc_cyc.push_back(cyc);
      if (data_ok) begin
        rsp_cyc.push_back(cyc);
        rsp_dat.push_back(rdata);
      end
      if (bp_out > bp_out_max) bp_out_max = bp_out;
      if (bp_req && bp_addr_ok) bp_out++;
      if (bp_data_ok) begin
        bp_out--;
        bp_rsp_dat.push_back(bp_rdata);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; wstrb = s; addr = a; wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; bp_req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); rsp_cyc.delete(); rsp_dat.delete(); bp_rsp_dat.delete();
  endtask

  task automatic bp_issue(input int n, input logic w, output int acc[8]);
    int done = 0;
    int guard = 0;
    while (done < n && guard < 60) begin
      bp_req = 1'b1; wr = w; wstrb = 4'hF;
      addr = 32'h40 + 32'(4 * done); wdata = 32'hB000_0000 + 32'(done);
      @(negedge clk);
      if (bp_addr_ok) begin
        acc[done] = cyc;
        done++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bp_req = 1'b0;
    check_eq("bp_accept_count", done, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_part [5];
    int acc[8];
    reset = 1'b1; req = 1'b0; bp_req = 1'b0; wr = 1'b0; hold = 1'b0;
    size = 2'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_data_ok", data_ok, 1'b0);
    check_eq("reset_rdata", rdata, 32'h0);
    reset = 1'b0;
    #1;
    check_eq("post_reset_addr_ok", addr_ok, 1'b1);
    hold = 1'b1;
    #1;
    check_eq("hold_addr_ok", addr_ok, 1'b0);
    hold = 1'b0;
    @(posedge clk); #1;

    // read after write
    clear_logs();
    drive(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    drive(1, 0, 4'h0, 32'h10, 32'h0);
    idle(6);
    check_eq("raw_accepts", acc_cyc.size(), 2);
    check_eq("raw_responses", rsp_cyc.size(), 2);
    if (rsp_cyc.size() >= 2 && acc_cyc.size() >= 1) begin
      check_eq("raw_wr_latency", rsp_cyc[0] - acc_cyc[0], 2);
      check_eq("raw_wr_rdata", rsp_dat[0], 32'h0);
      check_eq("raw_rd_latency", rsp_cyc[1] - acc_cyc[0], 3);
      check_eq("raw_rd_rdata", rsp_dat[1], 32'hDEAD_BEEF);
    end

    // partial strobes, zero strobe and address aliasing
    clear_logs();
    drive(1, 1, 4'hF, 32'h20, 32'h1122_3344);
    drive(1, 1, 4'h5, 32'h20, 32'hAABB_CCDD);
    drive(1, 1, 4'h0, 32'h20, 32'hFFFF_FFFF);
    drive(1, 0, 4'h0, 32'h20, 32'h0);
    drive(1, 0, 4'h0, 32'h1023, 32'h0);
    idle(6);
    exp_part = '{32'h0, 32'h0, 32'h0, 32'h11BB_33DD, 32'h11BB_33DD};
    check_eq("part_responses", rsp_dat.size(), 5);
    for (int i = 0; i < 5 && i < rsp_dat.size(); i++) begin
      check_eq($sformatf("part_rdata_%0d", i), rsp_dat[i], exp_part[i]);
      check_eq($sformatf("part_latency_%0d", i), rsp_cyc[i] - acc_cyc[i], 2);
    end

    // back-to-back reads
    drive(1, 1, 4'hF, 32'h0, 32'hA0A0_0000);
    drive(1, 1, 4'hF, 32'h4, 32'hA0A0_0004);
    drive(1, 1, 4'hF, 32'h8, 32'hA0A0_0008);
    idle(5);
    clear_logs();
    drive(1, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 4'h0, 32'h4, 32'h0);
    drive(1, 0, 4'h0, 32'h8, 32'h0);
    idle(6);
    check_eq("b2b_responses", rsp_dat.size(), 3);
    for (int i = 0; i < 3 && i < rsp_dat.size() && acc_cyc.size() > 0; i++) begin
      check_eq($sformatf("b2b_cycle_%0d", i), rsp_cyc[i] - acc_cyc[0], 2 + i);
      check_eq($sformatf("b2b_rdata_%0d", i), rsp_dat[i], 32'hA0A0_0000 + 32'(4 * i));
    end

    // hold with two requests pending
    clear_logs();
    drive(1, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 4'h0, 32'h4, 32'h0);
    req = 1'b1; addr = 32'h8; hold = 1'b1;
    @(negedge clk);
    check_eq("hold_blocks_addr_ok", addr_ok, 1'b0);
    @(posedge clk); #1;
    hold = 1'b0;
    idle(5);
    check_eq("hold_accepts", acc_cyc.size(), 2);
    check_eq("hold_responses", rsp_dat.size(), 2);
    if (rsp_dat.size() >= 2 && acc_cyc.size() >= 1) begin
      check_eq("hold_cycle_0", rsp_cyc[0] - acc_cyc[0], 2);
      check_eq("hold_cycle_1", rsp_cyc[1] - acc_cyc[0], 3);
      check_eq("hold_rdata_0", rsp_dat[0], 32'hA0A0_0000);
      check_eq("hold_rdata_1", rsp_dat[1], 32'hA0A0_0004);
    end

    // reset with reads in flight
    clear_logs();
    drive(1, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 4'h0, 32'h4, 32'h0);
    drive(1, 0, 4'h0, 32'h8, 32'h0);
    req = 1'b0;
    check_eq("pre_reset_data_ok", data_ok, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("midreset_data_ok", data_ok, 1'b0);
    check_eq("midreset_rdata", rdata, 32'h0);
    check_eq("midreset_addr_ok", addr_ok, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(8);
    check_eq("no_stale_responses", rsp_dat.size(), 1);
    clear_logs();
    drive(1, 0, 4'h0, 32'h10, 32'h0);
    idle(5);
    check_eq("kept_responses", rsp_dat.size(), 1);
    if (rsp_dat.size() >= 1) check_eq("kept_rdata", rsp_dat[0], 32'hDEAD_BEEF);

    // backpressure on the long-latency instance
    bp_issue(8, 1'b1, acc);
    idle(30);
    check_eq("bp_drained", bp_out, 0);
    bp_rsp_dat.delete();
    bp_out_max = 0;
    bp_issue(8, 1'b0, acc);
    check_eq("bp_first_four_gap", acc[3] - acc[0], 3);
    check_eq("bp_fifth_gap", acc[4] - acc[0], 7);
    idle(40);
    check_eq("bp_responses", bp_rsp_dat.size(), 8);
    for (int i = 0; i < 8 && i < bp_rsp_dat.size(); i++)
      check_eq($sformatf("bp_rdata_%0d", i), bp_rsp_dat[i], 32'hB000_0000 + 32'(i));
    check_eq("bp_max_outstanding", bp_out_max, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set the backing store depth to 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 1..15, SHALL set the minimum cycles from request acceptance to data_ok.
REQ-003 Parameter MAX_OUT, default 4, legal range 1..8, SHALL set the maximum number of outstanding unanswered requests.
REQ-004 Ports SHALL be:
 clk  input  1  sole clock; all state updates on its rising edge
 reset  input  1  asynchronous, active-high reset
 req  input  1  initiator request valid
 wr  input  1  1 = write, 0 = read
 size  input  2  access size (0 = byte, 1 = half, 2 = word); informational only
 wstrb  input  4  write byte-lane enables
 addr  input  32  byte address
 wdata  input  32  write data
 hold  input  1  test backpressure; forces addr_ok low
 addr_ok  output  1  request accepted this cycle when req is also high
 data_ok  output  1  one response returned this cycle
 rdata  output  32  response data, valid only while data_ok is high

Function
REQ-005 A request SHALL be accepted exactly in cycles where req && addr_ok.
REQ-006 addr_ok SHALL equal !hold && (outstanding count < MAX_OUT), combinational, independent of req.
REQ-007 Word index SHALL be addr[DEPTH_LOG2+1:2]; addr[1:0] and the upper address bits SHALL be ignored.
REQ-008 An accepted write SHALL update the indexed word on the acceptance edge, byte lane i only where wstrb[i]=1; wstrb=0 SHALL leave memory unchanged.
REQ-009 An accepted read SHALL sample the indexed word as it stands before the acceptance edge, i.e. including all writes accepted in earlier cycles.
REQ-010 Every accepted request, read or write, SHALL produce exactly one response; a write response SHALL carry rdata = 32'h0.
REQ-011 Responses SHALL be returned strictly in acceptance order, at most one per cycle.
REQ-012 A request accepted in cycle T SHALL be answered in cycle T+LATENCY if no earlier response is still pending, otherwise in the first cycle after its predecessor's response, never earlier than T+LATENCY.
REQ-013 data_ok SHALL be registered and high for exactly one cycle per response; rdata SHALL be 32'h0 whenever data_ok is low.
REQ-014 Outstanding count SHALL increment on acceptance and decrement on data_ok; simultaneous acceptance and data_ok SHALL leave the count unchanged.
REQ-015 Count = MAX_OUT SHALL drop addr_ok in the same cycle; a response in that cycle SHALL NOT raise addr_ok until the following cycle.
REQ-016 Each pending entry SHALL hold read data plus a saturating age counter of 4 bits; age SHALL count cycles since acceptance, saturating at LATENCY.
REQ-017 hold asserted SHALL NOT suppress or delay pending responses.
REQ-018 Internal FIFO pointers SHALL wrap modulo MAX_OUT without loss or duplication of entries.

Reset
REQ-019 reset SHALL asynchronously clear the outstanding count, FIFO pointers, and age counters, and force data_ok = 0 and rdata = 0.
REQ-020 reset SHALL NOT clear backing-store contents.
REQ-021 reset asserted with requests pending SHALL discard them; no data_ok for them SHALL appear after reset deasserts.
REQ-022 After reset deasserts, addr_ok SHALL be !hold.

Structure
REQ-023 The default LATENCY, MAX_OUT, and DEPTH_LOG2 values and the size encodings SHALL live in the shared package used by the pipeline stages.
REQ-024 The pending queue SHALL be a sub-module sram_resp_fifo, holding data and age per entry and exposing push, pop, head_ready, full, and count.
REQ-025 The backing store SHALL be a plain register array inferable as distributed RAM.

Verification
REQ-026 Read after write: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF in cycle T, then read 0x10 in T+1 -> data_ok with 0 in T+2 and with 0xDEADBEEF in T+3 (LATENCY=2).
REQ-027 Partial strobe: memory word 0x11223344; write wdata 0xAABBCCDD, wstrb 0x5 -> later read returns 0x11BB33DD.
REQ-028 Backpressure: MAX_OUT=4, req held high for 8 cycles -> addr_ok low after 4 acceptances, 8 in-order data_ok pulses in total, count never exceeds 4.
REQ-029 Back-to-back: reads of 0x0, 0x4, 0x8 in cycles T..T+2 -> data_ok in T+2, T+3, T+4 with the matching words in order.
REQ-030 hold: hold=1 in T+1 with two requests pending -> addr_ok=0 in T+1, both pending data_ok still delivered on schedule.
REQ-031 Reset mid-flight: 3 reads pending, reset pulsed -> data_ok=0 and count=0 immediately, no stale data_ok afterwards, previously written data still readable.
